mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the MIRI datapath, sitting directly downstream of the ALU stage and consuming its registered outputs (ALU result, forwarded register B data, zero flag, branch target, destination register). It issues loads and stores to data memory over a req/ack handshake, stalls the ALU stage while an access is outstanding, resolves taken branches, and presents one registered writeback record per retired instruction.

## Interface
- No parameters; datapath is 32 bits, register index is 5 bits.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- valid_in  in  1  ALU-stage record valid this cycle
- regDdata  in  32  ALU result; memory address for loads/stores
- regBdata  in  32  store data
- zero  in  1  ALU zero flag
- PCNEXT  in  32  branch target computed by ALU stage
- regD  in  5  destination register index
- mem_read, mem_write, is_byte, branch, reg_write  in  1 each  control bits travelling with the record
- stall  out  1  ALU stage must hold its outputs
- dmem_req  out  1  access request; dmem_we  out  1  1 = store
- dmem_addr  out  32; dmem_wdata  out  32; dmem_be  out  4  byte enables
- dmem_ack  in  1  access complete; dmem_rdata  in  32  load data, valid with ack
- wb_valid  out  1  one-cycle pulse per retired instruction
- wb_data  out  32; wb_regD  out  5; wb_reg_write  out  1
- pc_src  out  1  taken-branch pulse; pc_target  out  32
- align_err  out  1  misaligned-word pulse

## Operation
- FSM states IDLE, REQ. Reset → IDLE.
- IDLE, valid_in=1, no memory op: next edge registers wb_valid=1, wb_data=regDdata, wb_regD=regD, wb_reg_write=reg_write; stays IDLE.
- IDLE, valid_in=1, mem_read or mem_write: latches address, store data, control, regD; goes to REQ. mem_read and mem_write both high → treated as store.
- Word access with regDdata[1:0]≠0: no request issued; next edge wb_valid=1, wb_reg_write=0, align_err=1; stays IDLE.
- REQ: dmem_req=1; dmem_addr/we/wdata/be held stable from latched values until the ack edge. dmem_ack sampled high → IDLE, and at that edge wb_valid=1; loads write wb_data=aligned rdata, wb_reg_write=latched reg_write; stores force wb_reg_write=0.
- Byte store: dmem_be=4'b0001<<addr[1:0], dmem_wdata={4{regBdata[7:0]}}. Word: be=4'hF, wdata=regBdata.
- Byte load: lane addr[1:0] of dmem_rdata, sign-extended to 32 bits. Word load: rdata unchanged.
- Branch: pc_src = branch & zero of the accepted record, pc_target=PCNEXT, one-cycle pulse at the same edge the record is accepted (memory ops never carry branch=1; if they do, branch is still resolved at accept).
- stall = (state==REQ), Moore; the record presented during REQ is accepted in the first IDLE cycle.
- dmem_ack while IDLE ignored. valid_in=0 in IDLE: no outputs change except pulses return to 0.

## Timing
- Reset (async, mid-access included): state IDLE, dmem_req=0 immediately, all outputs 0, latched record discarded.
- Non-memory ops: latency 1 (wb_valid the cycle after valid_in).
- Memory ops: dmem_req rises the cycle after accept; earliest ack is that cycle, so minimum load/store latency 2 cycles; each extra wait cycle adds 1.
- Throughput: 1 record/cycle without memory ops; back-to-back memory ops: one per (wait+2) cycles.
- wb_valid, pc_src, align_err are one-cycle pulses; wb_data/wb_regD hold until next retire.

## Structure
- Package mem_stage_pkg: state enum (IDLE, REQ), BE_WORD=4'hF, BE_BYTE0=4'b0001, 32-bit data and 5-bit register-index width constants.
- Sub-module mem_align: pure combinational byte-lane store replication, byte-enable generation, load lane extract with sign extension; FSM and registers stay in mem_stage.

## Test plan
- ALU op: valid_in, regDdata=0x12, regD=3, reg_write=1 → next cycle wb_valid=1, wb_data=0x12, wb_regD=3, stall never high.
- Word load addr 0x100, ack after 2 wait cycles with rdata=0xDEADBEEF → stall high 3 cycles, dmem_addr=0x100, be=4'hF, wb_data=0xDEADBEEF.
- Byte load addr 0x103, rdata=0x80FFFFFF → be=4'b1000, wb_data=0xFFFFFF80; byte store addr 0x101 data 0xAB → wdata=0xABABABAB, be=4'b0010, wb_reg_write=0.
- Word load addr 0x102 → no dmem_req, align_err=1, wb_valid=1, wb_reg_write=0.
- branch=1, zero=1, PCNEXT=0x40 → pc_src=1, pc_target=0x40 for one cycle; zero=0 → pc_src=0.
- reset=0 during REQ → dmem_req=0 without clock edge; after release, new load issues normally with no stale wb_valid.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MIRI memory-access stage.
// Holds the FSM state encoding, byte-enable patterns and datapath widths.
package mem_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic [3:0] BE_WORD  = 4'hF;
  localparam logic [3:0] BE_BYTE0 = 4'b0001;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  // Word accesses must sit on a 4-byte boundary; byte accesses never fault
  function automatic logic is_misaligned(input logic [1:0] lane, input logic is_byte);
    return !is_byte && (lane != 2'b00);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage and data memory.
// master = memory stage (issues requests), slave = memory (acknowledges).
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        be;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ack, rdata
  );

endinterface

// File: rtl/mem_align.sv
// Byte-lane steering for the memory stage: store replication, byte enables
// and sign-extended load lane extraction. Purely combinational.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]        lane,
  input  logic              is_byte,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] load_data,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [7:0] load_byte;

  assign load_byte = load_data[{lane, 3'b000} +: 8];

  always_comb begin
    be    = BE_WORD;
    wdata = store_data;
    rdata = load_data;
    if (is_byte) begin
      // Replicating the byte lets memory pick it up from whichever lane is enabled
      be    = BE_BYTE0 << lane;
      wdata = {4{store_data[7:0]}};
      rdata = {{24{load_byte[7]}}, load_byte};
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MIRI memory-access stage: issues loads/stores over a req/ack bus, stalls the
// ALU stage while an access is outstanding, resolves branches, emits writeback.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] regDdata,
  input  logic [DATA_W-1:0] regBdata,
  input  logic              zero,
  input  logic [DATA_W-1:0] PCNEXT,
  input  logic [REG_W-1:0]  regD,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              is_byte,
  input  logic              branch,
  input  logic              reg_write,
  output logic              stall,
  mem_stage_if.master       dmem,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_regD,
  output logic              wb_reg_write,
  output logic              pc_src,
  output logic [DATA_W-1:0] pc_target,
  output logic              align_err
);

  state_t state, next_state;

  logic              accept;
  logic              mem_op;
  logic              misaligned;

  logic [DATA_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_store;
  logic              lat_we;
  logic              lat_byte;
  logic              lat_reg_write;
  logic [REG_W-1:0]  lat_regD;

  logic [3:0]        align_be;
  logic [DATA_W-1:0] align_wdata;
  logic [DATA_W-1:0] align_rdata;

  assign accept     = (state == IDLE) && valid_in;
  assign mem_op     = mem_read || mem_write;
  assign misaligned = mem_op && is_misaligned(regDdata[1:0], is_byte);

  mem_align u_align (
    .lane       (lat_addr[1:0]),
    .is_byte    (lat_byte),
    .store_data (lat_store),
    .load_data  (dmem.rdata),
    .be         (align_be),
    .wdata      (align_wdata),
    .rdata      (align_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept && mem_op && !misaligned) next_state = REQ;
      REQ:  if (dmem.ack)                        next_state = IDLE;
      default:                                   next_state = IDLE;
    endcase
  end

  // Bus fields are gated so nothing stale is visible outside an access
  always_comb begin
    stall      = (state == REQ);
    dmem.req   = (state == REQ);
    dmem.we    = (state == REQ) && lat_we;
    dmem.addr  = (state == REQ) ? lat_addr    : '0;
    dmem.wdata = (state == REQ) ? align_wdata : '0;
    dmem.be    = (state == REQ) ? align_be    : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_addr      <= '0;
      lat_store     <= '0;
      lat_we        <= 1'b0;
      lat_byte      <= 1'b0;
      lat_reg_write <= 1'b0;
      lat_regD      <= '0;
      wb_valid      <= 1'b0;
      wb_data       <= '0;
      wb_regD       <= '0;
      wb_reg_write  <= 1'b0;
      pc_src        <= 1'b0;
      pc_target     <= '0;
      align_err     <= 1'b0;
    end else begin
      wb_valid  <= 1'b0;
      pc_src    <= 1'b0;
      align_err <= 1'b0;
      if (accept) begin
        pc_src <= branch && zero;
        if (branch && zero) pc_target <= PCNEXT;
        if (!mem_op) begin
          wb_valid     <= 1'b1;
          wb_data      <= regDdata;
          wb_regD      <= regD;
          wb_reg_write <= reg_write;
        end else if (misaligned) begin
          wb_valid     <= 1'b1;
          wb_data      <= regDdata;
          wb_regD      <= regD;
          wb_reg_write <= 1'b0;
          align_err    <= 1'b1;
        end else begin
          // A record with both read and write set is handled as a store
          lat_addr      <= regDdata;
          lat_store     <= regBdata;
          lat_we        <= mem_write;
          lat_byte      <= is_byte;
          lat_reg_write <= reg_write;
          lat_regD      <= regD;
        end
      end else if ((state == REQ) && dmem.ack) begin
        wb_valid <= 1'b1;
        wb_regD  <= lat_regD;
        if (lat_we) begin
          wb_reg_write <= 1'b0;
        end else begin
          wb_data      <= align_rdata;
          wb_reg_write <= lat_reg_write;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: ALU retire, word/byte loads and
// stores, misaligned access, branch resolution and asynchronous reset mid-access.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic [31:0] regDdata;
  logic [31:0] regBdata;
  logic        zero;
  logic [31:0] PCNEXT;
  logic [4:0]  regD;
  logic        mem_read;
  logic        mem_write;
  logic        is_byte;
  logic        branch;
  logic        reg_write;
  logic        stall;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_regD;
  logic        wb_reg_write;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        align_err;

  int check_count = 0;
  int pass_count  = 0;

  mem_stage_if dmem ();

  mem_stage dut (
    .clk          (clk),
    .reset        (reset),
    .valid_in     (valid_in),
    .regDdata     (regDdata),
    .regBdata     (regBdata),
    .zero         (zero),
    .PCNEXT       (PCNEXT),
    .regD         (regD),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .is_byte      (is_byte),
    .branch       (branch),
    .reg_write    (reg_write),
    .stall        (stall),
    .dmem         (dmem),
    .wb_valid     (wb_valid),
    .wb_data      (wb_data),
    .wb_regD      (wb_regD),
    .wb_reg_write (wb_reg_write),
    .pc_src       (pc_src),
    .pc_target    (pc_target),
    .align_err    (align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [31:0] b,
                               input logic z, input logic [31:0] pcn, input logic [4:0] rd,
                               input logic mr, input logic mw, input logic byt,
                               input logic br, input logic rw);
    @(negedge clk);
    valid_in  = v;
    regDdata  = d;
    regBdata  = b;
    zero      = z;
    PCNEXT    = pcn;
    regD      = rd;
    mem_read  = mr;
    mem_write = mw;
    is_byte   = byt;
    branch    = br;
    reg_write = rw;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired, run did not complete");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset      = 1'b0;
    valid_in   = 1'b0;
    regDdata   = '0;
    regBdata   = '0;
    zero       = 1'b0;
    PCNEXT     = '0;
    regD       = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    is_byte    = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    dmem.ack   = 1'b0;
    dmem.rdata = '0;

    #2;
    checkOutput("rst_stall",    stall,        0);
    checkOutput("rst_req",      dmem.req,     0);
    checkOutput("rst_be",       dmem.be,      0);
    checkOutput("rst_wb_valid", wb_valid,     0);
    checkOutput("rst_wb_data",  wb_data,      0);
    checkOutput("rst_pc_src",   pc_src,       0);
    checkOutput("rst_align",    align_err,    0);

    @(negedge clk);
    reset = 1'b1;

    // ALU op retires one cycle after acceptance
    applyStimulus(1'b1, 32'h12, 32'h0, 1'b0, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("alu_wb_valid", wb_valid,     1);
    checkOutput("alu_wb_data",  wb_data,      32'h12);
    checkOutput("alu_wb_regD",  wb_regD,      3);
    checkOutput("alu_wb_rw",    wb_reg_write, 1);
    checkOutput("alu_stall",    stall,        0);
    idleInputs();
    tick();
    checkOutput("alu_pulse_end", wb_valid,    0);
    checkOutput("alu_data_hold", wb_data,     32'h12);

    // Word load with two wait cycles
    applyStimulus(1'b1, 32'h100, 32'h0, 1'b0, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("wl_stall1",  stall,     1);
    checkOutput("wl_req",     dmem.req,  1);
    checkOutput("wl_addr",    dmem.addr, 32'h100);
    checkOutput("wl_be",      dmem.be,   4'hF);
    checkOutput("wl_we",      dmem.we,   0);
    checkOutput("wl_novalid", wb_valid,  0);
    idleInputs();
    tick();
    checkOutput("wl_stall2",  stall,     1);
    checkOutput("wl_addr2",   dmem.addr, 32'h100);
    tick();
    checkOutput("wl_stall3",  stall,     1);
    @(negedge clk);
    dmem.ack   = 1'b1;
    dmem.rdata = 32'hDEADBEEF;
    tick();
    checkOutput("wl_stall_end", stall,        0);
    checkOutput("wl_req_end",   dmem.req,     0);
    checkOutput("wl_wb_valid",  wb_valid,     1);
    checkOutput("wl_wb_data",   wb_data,      32'hDEADBEEF);
    checkOutput("wl_wb_regD",   wb_regD,      5);
    checkOutput("wl_wb_rw",     wb_reg_write, 1);
    @(negedge clk);
    dmem.ack = 1'b0;

    // Byte load from lane 3, sign-extended
    applyStimulus(1'b1, 32'h103, 32'h0, 1'b0, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("bl_be",  dmem.be,  4'b1000);
    checkOutput("bl_req", dmem.req, 1);
    idleInputs();
    dmem.ack   = 1'b1;
    dmem.rdata = 32'h80FFFFFF;
    tick();
    checkOutput("bl_wb_valid", wb_valid, 1);
    checkOutput("bl_wb_data",  wb_data,  32'hFFFFFF80);
    @(negedge clk);
    dmem.ack = 1'b0;

    // Byte store to lane 1
    applyStimulus(1'b1, 32'h101, 32'h123456AB, 1'b0, 32'h0, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("bs_wdata", dmem.wdata, 32'hABABABAB);
    checkOutput("bs_be",    dmem.be,    4'b0010);
    checkOutput("bs_we",    dmem.we,    1);
    checkOutput("bs_addr",  dmem.addr,  32'h101);
    idleInputs();
    dmem.ack = 1'b1;
    tick();
    checkOutput("bs_wb_valid", wb_valid,     1);
    checkOutput("bs_wb_rw",    wb_reg_write, 0);
    @(negedge clk);
    dmem.ack = 1'b0;

    // Misaligned word load
    applyStimulus(1'b1, 32'h102, 32'h0, 1'b0, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("ma_req",      dmem.req,     0);
    checkOutput("ma_stall",    stall,        0);
    checkOutput("ma_align",    align_err,    1);
    checkOutput("ma_wb_valid", wb_valid,     1);
    checkOutput("ma_wb_rw",    wb_reg_write, 0);
    idleInputs();
    tick();
    checkOutput("ma_align_end", align_err, 0);
    checkOutput("ma_valid_end", wb_valid,  0);

    // Taken and not-taken branches
    applyStimulus(1'b1, 32'h0, 32'h0, 1'b1, 32'h40, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("br_pc_src",    pc_src,    1);
    checkOutput("br_pc_target", pc_target, 32'h40);
    idleInputs();
    tick();
    checkOutput("br_pulse_end", pc_src, 0);
    applyStimulus(1'b1, 32'h0, 32'h0, 1'b0, 32'h80, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    checkOutput("br_not_taken", pc_src, 0);

    // Stray ack while idle must do nothing
    idleInputs();
    dmem.ack = 1'b1;
    tick();
    checkOutput("ia_req",      dmem.req, 0);
    checkOutput("ia_stall",    stall,    0);
    checkOutput("ia_wb_valid", wb_valid, 0);
    @(negedge clk);
    dmem.ack = 1'b0;

    // Asynchronous reset in the middle of an access
    applyStimulus(1'b1, 32'h200, 32'h0, 1'b0, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("ar_req_before", dmem.req, 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("ar_req_async",   dmem.req, 0);
    checkOutput("ar_stall_async", stall,    0);
    checkOutput("ar_be_async",    dmem.be,  0);
    checkOutput("ar_wb_data",     wb_data,  0);
    idleInputs();
    reset = 1'b1;
    tick();
    checkOutput("ar_no_stale_wb", wb_valid, 0);
    checkOutput("ar_req_idle",    dmem.req, 0);

    // Fresh load after reset release
    applyStimulus(1'b1, 32'h300, 32'h0, 1'b0, 32'h0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("nl_req",  dmem.req,  1);
    checkOutput("nl_addr", dmem.addr, 32'h300);
    idleInputs();
    dmem.ack   = 1'b1;
    dmem.rdata = 32'h11223344;
    tick();
    checkOutput("nl_wb_valid", wb_valid, 1);
    checkOutput("nl_wb_data",  wb_data,  32'h11223344);
    checkOutput("nl_wb_regD",  wb_regD,  10);
    @(negedge clk);
    dmem.ack = 1'b0;

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
